sram_like_arbiter: RTL
======================

# sram_like_arbiter

Arbitrates the single SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (MEM stage, driven from the EX_MEM data_sram fields). It latches one request at a time, drives it to memory, and routes the addr_ok/data_ok handshakes back to the owner. Only one transaction is outstanding. Its busy indications feed the stall logic that drives memory_stall and MEM_stall in the pipeline registers.

## Interface
Parameters:
- RESET_ADDR, 32'hbfc00000, value of the latched address register after reset.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_req  in  1  IF request. Held high until inst_addr_ok.
- inst_addr  in  32  fetch address.
- inst_cancel  in  1  flush of the outstanding or pending fetch.
- inst_addr_ok  out  1  IF request accepted by memory.
- inst_data_ok  out  1  fetch data valid.
- inst_rdata  out  32  fetch data. Passes mem_rdata through.
- data_req  in  1  MEM request. Held high until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  data address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted.
- data_data_ok  out  1  load data valid, or store complete.
- data_rdata  out  32  load data. Passes mem_rdata through.
- mem_req  out  1  request to memory.
- mem_wr  out  1  write enable.
- mem_size  out  2  transfer size.
- mem_addr  out  32  address.
- mem_wdata  out  32  write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory completed the transaction.
- mem_rdata  in  32  read data.
- inst_busy  out  1  inst_req is high and inst_data_ok has not yet been returned.
- data_busy  out  1  data_req is high, or a data transaction is outstanding.

## Operation
State machine states: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT. One additional bit, last_was_data, records who owned the previous grant.

IDLE:
- Only data_req: latch wr, size, addr, wdata. Go to D_ADDR.
- Only inst_req (and inst_cancel low): latch addr, wr=0, size=2. Go to I_ADDR.
- Both requesting: data wins unless last_was_data=1, in which case inst wins. This prevents IF starvation on back-to-back loads and stores.
- last_was_data updates on every grant.

I_ADDR / D_ADDR:
- mem_req=1, driven from the latched registers.
- When mem_addr_ok=1, pulse the owner's *_addr_ok in the same cycle and go to the matching *_WAIT state.

I_WAIT / D_WAIT:
- mem_req=0.
- When mem_data_ok=1, pulse the owner's *_data_ok in the same cycle and go to IDLE.

Cancel:
- inst_cancel in I_ADDR with mem_addr_ok=0: drop the request and go to IDLE. mem_req is low next cycle.
- inst_cancel in I_ADDR with mem_addr_ok=1: go to I_WAIT with the drop flag set.
- inst_cancel in I_WAIT: set the drop flag.
- When the drop flag is set, the matching mem_data_ok is consumed with inst_data_ok held at 0. The flag clears on return to IDLE.
- inst_cancel has no effect on data transactions.
- inst_cancel high in IDLE blocks an inst grant that cycle.

Other rules:
- An ack arriving in the wrong state is ignored and never forwarded. This covers mem_data_ok in IDLE/ADDR states and mem_addr_ok in WAIT states.
- inst_rdata and data_rdata equal mem_rdata at all times. Only the *_data_ok strobes qualify them.

## Timing
- Reset values: state=IDLE, last_was_data=0, drop=0, mem_req=0, mem_wr=0, mem_size=0, mem_addr=RESET_ADDR, mem_wdata=0.
- Reset values of the ack outputs: all *_addr_ok and *_data_ok are 0.
- Reset values of the busy outputs: inst_busy and data_busy follow their combinational definitions, so both are 0 when their requests are low.
- Request to mem_req latency is 1 cycle: request seen in IDLE at edge N, mem_req high after edge N.
- addr_ok and data_ok are forwarded combinationally with zero added latency.
- Minimum transaction with mem_addr_ok=1 on the first mem_req cycle and mem_data_ok the next cycle:
  - 3 cycles from grant to IDLE (IDLE → ADDR → WAIT → IDLE).
  - A new request can be granted on the cycle after data_ok.
- Reset mid-transaction returns to IDLE on the next edge. A late mem_data_ok after reset is ignored, since the memory side is reset by the same rst.
- Latched fields are stable for the whole ADDR state. Changes on requester inputs after the grant are ignored.

## Test plan
- Single load: data_req, data_addr=0x1000, data_size=2. Memory gives addr_ok on the first cycle and data_ok 2 cycles later with rdata=0xDEADBEEF.
  - Required: mem_req high for exactly 1 cycle with mem_addr=0x1000.
  - Required: data_data_ok high for 1 cycle with data_rdata=0xDEADBEEF.
  - Required: inst_addr_ok and inst_data_ok never asserted.
- Contention: inst_req and data_req held continuously.
  - Required grant order: data, inst, data, inst.
  - Required: each requester's addr_ok occurs only while it owns the port.
- Memory backpressure: mem_addr_ok held low for 4 cycles on a store to 0x2004, wdata=0x55AA55AA, size=1.
  - Required: mem_req, mem_addr and mem_wdata stable for all 5 cycles.
  - Required: a single data_addr_ok pulse.
- Cancel in I_WAIT: fetch 0xbfc00010 accepted, then inst_cancel pulsed before mem_data_ok.
  - Required: inst_data_ok stays 0.
  - Required: state returns to IDLE after mem_data_ok.
  - Required: the next fetch to 0xbfc00100 completes normally.
- Cancel in I_ADDR with mem_addr_ok=0: mem_req is low the next cycle and no ack is produced.
- Reset mid-transaction: rst asserted in D_WAIT, then a stray mem_data_ok arrives.
  - Required: all outputs at their reset values.
  - Required: no data_data_ok is produced.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and the data stage.
// One transaction in flight; grants alternate when both sides contend.
module sram_like_arbiter #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        inst_busy,
    output logic        data_busy
);

    typedef enum logic [2:0] {IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT} state_t;

    state_t      state, state_nxt;
    logic        last_was_data;
    logic        drop, drop_nxt;
    logic        grant_inst, grant_data;
    logic        inst_ok;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    assign inst_ok = inst_req && !inst_cancel;

    always_comb begin
        state_nxt    = state;
        drop_nxt     = drop;
        grant_inst   = 1'b0;
        grant_data   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            IDLE: begin
                drop_nxt = 1'b0;
                // Data normally wins; after a data grant the fetch gets its turn.
                if (data_req && !(inst_ok && last_was_data)) begin
                    grant_data = 1'b1;
                    state_nxt  = D_ADDR;
                end else if (inst_ok) begin
                    grant_inst = 1'b1;
                    state_nxt  = I_ADDR;
                end
            end
            I_ADDR: begin
                if (mem_addr_ok) begin
                    inst_addr_ok = 1'b1;
                    drop_nxt     = inst_cancel;
                    state_nxt    = I_WAIT;
                end else if (inst_cancel) begin
                    state_nxt = IDLE;
                end
            end
            I_WAIT: begin
                if (inst_cancel) drop_nxt = 1'b1;
                if (mem_data_ok) begin
                    inst_data_ok = !(drop || inst_cancel);
                    drop_nxt     = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            D_ADDR: begin
                if (mem_addr_ok) begin
                    data_addr_ok = 1'b1;
                    state_nxt    = D_WAIT;
                end
            end
            D_WAIT: begin
                if (mem_data_ok) begin
                    data_data_ok = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_was_data <= 1'b0;
            drop          <= 1'b0;
            wr_q          <= 1'b0;
            size_q        <= 2'd0;
            addr_q        <= RESET_ADDR;
            wdata_q       <= 32'd0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            if (grant_data) begin
                last_was_data <= 1'b1;
                wr_q          <= data_wr;
                size_q        <= data_size;
                addr_q        <= data_addr;
                wdata_q       <= data_wdata;
            end else if (grant_inst) begin
                last_was_data <= 1'b0;
                wr_q          <= 1'b0;
                size_q        <= 2'd2;
                addr_q        <= inst_addr;
            end
        end
    end

    assign mem_req    = (state == I_ADDR) || (state == D_ADDR);
    assign mem_wr     = wr_q;
    assign mem_size   = size_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;
    assign inst_busy  = inst_req && !inst_data_ok;
    assign data_busy  = data_req || (state == D_ADDR) || (state == D_WAIT);

endmodule
